obstacle_pool: RTL

OBSTACLE_POOL -- requirements
Module: obstacle_pool

---
 rtl/obstacle_pool_pkg.sv | 26 ++
 rtl/lfsr16.sv | 31 +++
 rtl/obstacle_pool.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/obstacle_pool_pkg.sv
// Shared geometry constants and the per-slot obstacle record for the obstacle pool.
package obstacle_pool_pkg;

    localparam int CW               = 12;
    localparam int IWIDTH_DEF       = 12;
    localparam int D_WIDTH_DEF      = 640;
    localparam int FLOOR_Y_DEF      = 400;
    localparam int CACTUS_HMIN_DEF  = 16;
    localparam int BIRD_H_DEF       = 8;
    localparam int BIRD_YMAX_DEF    = 380;

    typedef logic signed [CW-1:0] coord_t;

    typedef struct packed {
        logic   active;
        logic   bird;
        coord_t x;
        coord_t y;
        coord_t hh;
    } slot_t;

    function automatic coord_t to_coord(input int v);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps only when enabled.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       en_i,
    output logic [7:0] rnd_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    // Only the low byte drives obstacle selection.
    assign rnd_o = state_q[7:0];

endmodule

// File: rtl/obstacle_pool.sv
// Pool of scrolling obstacles: spawns cacti/birds at the right edge, scrolls them
// left at a ramping speed and retires them once they leave the screen.
module obstacle_pool
    import obstacle_pool_pkg::*;
#(
    parameter int          N_OBS       = 3,
    parameter int          IWIDTH      = IWIDTH_DEF,
    parameter int          D_WIDTH     = D_WIDTH_DEF,
    parameter int          FLOOR_Y     = FLOOR_Y_DEF,
    parameter int          CACTUS_HMIN = CACTUS_HMIN_DEF,
    parameter int          BIRD_H      = BIRD_H_DEF,
    parameter int          BIRD_YMAX   = BIRD_YMAX_DEF,
    parameter int          MIN_GAP     = 160,
    parameter int          WAIT_MIN    = 40,
    parameter int          VEL_INIT    = 2,
    parameter int          VEL_MAX     = 8,
    parameter int          RAMP_FRAMES = 600,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ani_stb,
    input  logic                  i_animate,
    input  logic                  i_grace,
    output logic [CW*N_OBS-1:0]   o_x1,
    output logic [CW*N_OBS-1:0]   o_x2,
    output logic [CW*N_OBS-1:0]   o_y1,
    output logic [CW*N_OBS-1:0]   o_y2,
    output logic [N_OBS-1:0]      o_active,
    output logic [N_OBS-1:0]      o_type,
    output logic [3:0]            o_vel,
    output logic                  o_spawn
);

    localparam coord_t SPAWN_X  = to_coord(D_WIDTH + IWIDTH);
    localparam coord_t RETIRE_X = to_coord(-IWIDTH - 1);
    localparam coord_t GAP_X    = to_coord(D_WIDTH - MIN_GAP - IWIDTH);
    localparam coord_t HALF_W   = to_coord(IWIDTH);

    slot_t       slot_q [N_OBS];
    slot_t       slot_d [N_OBS];
    logic [15:0] timer_q, timer_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  vel_q, vel_d;
    logic        spawn_q;

    logic        frame, spawn_go, gap_ok, any_free, placed;
    logic [7:0]  rnd;
    coord_t      nib, nib_x4, vel_c, cactus_hh;
    slot_t       new_slot;
    logic [15:0] reload;

    assign frame = i_ani_stb & i_animate;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .en_i  (frame),
        .rnd_o (rnd)
    );

    // New obstacle drawn from the LFSR value present at frame start.
    always_comb begin
        nib       = {{(CW-4){1'b0}}, rnd[3:0]};
        nib_x4    = {{(CW-6){1'b0}}, rnd[3:0], 2'b00};
        cactus_hh = to_coord(CACTUS_HMIN) + nib;
        reload    = 16'(WAIT_MIN) + {10'b0, rnd[7:5], 3'b000};

        new_slot.active = 1'b1;
        new_slot.bird   = rnd[4];
        new_slot.x      = SPAWN_X;
        if (rnd[4]) begin
            new_slot.hh = to_coord(BIRD_H);
            new_slot.y  = to_coord(BIRD_YMAX) - nib_x4;
        end else begin
            new_slot.hh = cactus_hh;
            new_slot.y  = to_coord(FLOOR_Y) - cactus_hh;
        end
    end

    always_comb begin
        vel_c    = {{(CW-4){1'b0}}, vel_q};
        gap_ok   = 1'b1;
        any_free = 1'b0;
        for (int k = 0; k < N_OBS; k++) begin
            if (!slot_q[k].active) begin
                any_free = 1'b1;
            end else if ($signed(slot_q[k].x) > $signed(GAP_X)) begin
                gap_ok = 1'b0;
            end
        end
        spawn_go = frame & ~i_grace & (timer_q == '0) & any_free & gap_ok;

        // Retiring slots are still active here, so they can never take the spawn.
        placed = 1'b0;
        for (int k = 0; k < N_OBS; k++) begin
            slot_d[k] = slot_q[k];
            if (slot_q[k].active) begin
                if ($signed(slot_q[k].x) <= $signed(RETIRE_X)) begin
                    slot_d[k].active = 1'b0;
                end else begin
                    slot_d[k].x = slot_q[k].x - vel_c;
                end
            end else if (spawn_go && !placed) begin
                slot_d[k] = new_slot;
                placed    = 1'b1;
            end
        end

        timer_d = timer_q;
        if (!i_grace) begin
            if (timer_q != '0) begin
                timer_d = timer_q - 16'd1;
            end else if (spawn_go) begin
                timer_d = reload;
            end
        end

        cnt_d = cnt_q + 16'd1;
        vel_d = vel_q;
        if (cnt_q == 16'(RAMP_FRAMES - 1)) begin
            cnt_d = '0;
            if (vel_q < 4'(VEL_MAX)) begin
                vel_d = vel_q + 4'd1;
            end
        end
    end

    // Slot geometry is don't-care while inactive, so only the active flags reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_OBS; k++) begin
                slot_q[k].active <= 1'b0;
            end
            timer_q <= 16'(WAIT_MIN);
            cnt_q   <= '0;
            vel_q   <= 4'(VEL_INIT);
            spawn_q <= 1'b0;
        end else begin
            spawn_q <= spawn_go;
            if (frame) begin
                slot_q  <= slot_d;
                timer_q <= timer_d;
                cnt_q   <= cnt_d;
                vel_q   <= vel_d;
            end
        end
    end

    always_comb begin
        o_x1     = '0;
        o_x2     = '0;
        o_y1     = '0;
        o_y2     = '0;
        o_active = '0;
        o_type   = '0;
        for (int k = 0; k < N_OBS; k++) begin
            o_active[k] = slot_q[k].active;
            if (slot_q[k].active) begin
                o_x1[CW*k +: CW] = slot_q[k].x - HALF_W;
                o_x2[CW*k +: CW] = slot_q[k].x + HALF_W;
                o_y1[CW*k +: CW] = slot_q[k].y - slot_q[k].hh;
                o_y2[CW*k +: CW] = slot_q[k].y + slot_q[k].hh;
                o_type[k]        = slot_q[k].bird;
            end
        end
    end

    assign o_vel   = vel_q;
    assign o_spawn = spawn_q;

endmodule
